// File: rtl/bp_pkg.sv
// Shared definitions for the gshare global branch predictor.
package bp_pkg;

    // Default history length; the PHT has 2^GHR_W_DEF two-bit counters.
    localparam int GHR_W_DEF = 8;

    // Two-bit saturating counter encodings.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // In-flight lookup record carried from fetch through decode to execute.
    // Sized by GHR_W_DEF; a different history length means changing both together.
    typedef struct packed {
        logic                 branch;
        logic [GHR_W_DEF-1:0] idx;
        logic                 pred;
        logic [GHR_W_DEF-1:0] ghr;
    } snap_t;

    // Saturating step of a two-bit counter toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != ST))
            nxt = ctr + 2'd1;
        else if (!taken && (ctr != SNT))
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2^IDX_W two-bit counters, async read, sync saturating update.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = GHR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int N = 1 << IDX_W;

    logic [1:0] cnt_q [N];
    logic [1:0] cnt_d;

    // Lookup sees the stored value only; a same-cycle write is not bypassed.
    always_comb begin
        rd_ctr = cnt_q[rd_idx];
        cnt_d  = ctr_next(cnt_q[upd_idx], upd_taken);
    end

    // Every counter starts weakly not-taken; one entry trains per resolved branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                cnt_q[i] <= WNT;
        end else if (upd_en) begin
            cnt_q[upd_idx] <= cnt_d;
        end
    end

endmodule

// File: rtl/global_branch_pred.sv
// Gshare predictor beside fetch: speculative GHR, F->D and D->E lookup snapshots,
// execute-stage training, mispredict recovery and statistics.
module global_branch_pred
    import bp_pkg::*;
#(
    parameter int GHR_W = GHR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        flushE,
    input  logic        branchD,
    input  logic        actual_takenE,
    output logic        pred_takenF,
    output logic        pred_takenD,
    output logic        mispredictE,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    logic [GHR_W-1:0] ghr_spec_q, ghr_spec_d;
    snap_t            fd_q, fd_d;
    snap_t            de_q, de_d;
    logic [31:0]      branch_cnt_q, branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic [GHR_W-1:0] idx_f;
    logic [1:0]       ctr_f;
    logic             unused_bits;

    assign idx_f       = pcF[GHR_W+1:2] ^ ghr_spec_q;
    assign pred_takenF = ctr_f[1];
    assign pred_takenD = fd_q.pred;
    assign mispredictE = de_q.branch && (de_q.pred != actual_takenE);
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign unused_bits = ^{pcF[31:GHR_W+2], pcF[1:0], ctr_f[0], fd_q.branch};

    gshare_pht #(.IDX_W(GHR_W)) u_pht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx_f),
        .rd_ctr    (ctr_f),
        .upd_en    (de_q.branch),
        .upd_idx   (de_q.idx),
        .upd_taken (actual_takenE)
    );

    // F->D snapshot: flush clears it, stall holds it, otherwise capture the lookup.
    always_comb begin
        fd_d = fd_q;
        if (flushD) begin
            fd_d = '0;
        end else if (!stallD) begin
            fd_d.branch = 1'b0;
            fd_d.idx    = idx_f;
            fd_d.pred   = pred_takenF;
            fd_d.ghr    = ghr_spec_q;
        end
    end

    // D->E snapshot: a stalled or flushed decode sends a bubble into execute.
    always_comb begin
        de_d        = fd_q;
        de_d.branch = branchD;
        if (flushE || stallD)
            de_d = '0;
    end

    // History update (recovery beats speculation) and statistics.
    always_comb begin
        ghr_spec_d    = ghr_spec_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (mispredictE)
            ghr_spec_d = {de_q.ghr[GHR_W-2:0], actual_takenE};
        else if (branchD && !stallD && !flushE)
            ghr_spec_d = {ghr_spec_q[GHR_W-2:0], pred_takenD};
        if (de_q.branch)
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredictE)
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    // All predictor state; reset discards every in-flight snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_spec_q    <= '0;
            fd_q          <= '0;
            de_q          <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_spec_q    <= ghr_spec_d;
            fd_q          <= fd_d;
            de_q          <= de_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_global_branch_pred.sv
// Self-checking bench for global_branch_pred with a behavioural reference model.
module tb_global_branch_pred;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD, flushD, flushE, branchD, actual_takenE;
    logic        pred_takenF, pred_takenD, mispredictE;
    logic [31:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    global_branch_pred #(.GHR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pcF           (pcF),
        .stallD        (stallD),
        .flushD        (flushD),
        .flushE        (flushE),
        .branchD       (branchD),
        .actual_takenE (actual_takenE),
        .pred_takenF   (pred_takenF),
        .pred_takenD   (pred_takenD),
        .mispredictE   (mispredictE),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counters as integers 0..3, history as an integer 0..255,
    // and one record per in-flight lookup in D and E.
    int          m_pht [256];
    int          m_ghr;
    int          m_fd_idx, m_fd_pred, m_fd_ghr;
    int          m_de_br, m_de_idx, m_de_pred, m_de_ghr;
    int unsigned m_bcnt, m_mcnt;

    function automatic int m_idx(input logic [31:0] pc);
        return ((pc >> 2) ^ m_ghr) & 255;
    endfunction

    function automatic bit m_predF();
        return m_pht[m_idx(pcF)] >= 2;
    endfunction

    function automatic bit m_mis();
        return (m_de_br != 0) && (m_de_pred != int'(actual_takenE));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_fd_idx = 0; m_fd_pred = 0; m_fd_ghr = 0;
        m_de_br = 0; m_de_idx = 0; m_de_pred = 0; m_de_ghr = 0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    task automatic model_step();
        int idx, pf, ng;
        bit mis;
        idx = m_idx(pcF);
        pf  = (m_pht[idx] >= 2) ? 1 : 0;
        mis = m_mis();
        ng  = m_ghr;
        if (mis)
            ng = ((m_de_ghr << 1) | int'(actual_takenE)) & 255;
        else if (branchD && !stallD && !flushE)
            ng = ((m_ghr << 1) | m_fd_pred) & 255;
        if (m_de_br != 0) begin
            if (actual_takenE) m_pht[m_de_idx] = (m_pht[m_de_idx] == 3) ? 3 : m_pht[m_de_idx] + 1;
            else               m_pht[m_de_idx] = (m_pht[m_de_idx] == 0) ? 0 : m_pht[m_de_idx] - 1;
            m_bcnt++;
        end
        if (mis) m_mcnt++;
        if (flushE || stallD) begin
            m_de_br = 0; m_de_idx = 0; m_de_pred = 0; m_de_ghr = 0;
        end else begin
            m_de_br = int'(branchD); m_de_idx = m_fd_idx; m_de_pred = m_fd_pred; m_de_ghr = m_fd_ghr;
        end
        if (flushD) begin
            m_fd_idx = 0; m_fd_pred = 0; m_fd_ghr = 0;
        end else if (!stallD) begin
            m_fd_idx = idx; m_fd_pred = pf; m_fd_ghr = m_ghr;
        end
        m_ghr = ng;
    endtask

    // One clock: the model advances on the same edge as the DUT, then settle.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic idle_inputs();
        pcF = '0; stallD = 0; flushD = 0; flushE = 0; branchD = 0; actual_takenE = 0;
    endtask

    // Fetch, decode and resolve a single branch with nothing else in flight.
    task automatic run_branch(input logic [31:0] pc, input bit taken,
                              output bit pf_obs, output bit pf_exp,
                              output bit mis_obs, output bit mis_exp);
        idle_inputs();
        pcF = pc; #1;
        pf_obs = pred_takenF; pf_exp = m_predF();
        step();
        pcF = '0; branchD = 1; #1;
        step();
        branchD = 0; actual_takenE = taken; #1;
        mis_obs = mispredictE; mis_exp = m_mis();
        step();
        actual_takenE = 0;
    endtask

    // Shift zeros into the history with not-taken filler branches until it is clear.
    task automatic clear_hist();
        bit a, b, c, d;
        for (int k = 0; k < 10 && m_ghr != 0; k++)
            run_branch(32'h0000_0200, 1'b0, a, b, c, d);
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); actual_takenE = 1; #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            pcF = $urandom; #1;
            n_tests++;
            if (pred_takenF !== 1'b0) begin n_fail++; $display("FAIL reset_predF: got %b want 0", pred_takenF); end
        end
        n_tests++;
        if (pred_takenD !== 1'b0 || mispredictE !== 1'b0) begin
            n_fail++; $display("FAIL reset_outs: predD %b misE %b want 0 0", pred_takenD, mispredictE);
        end
        n_tests++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || dut.ghr_spec_q !== 8'd0) begin
            n_fail++; $display("FAIL reset_state: bcnt %0d mcnt %0d ghr %0h want 0 0 0", branch_cnt, mispred_cnt, dut.ghr_spec_q);
        end
        step();
        rst = 0; idle_inputs();
        step();
    endtask

    task automatic test_training();
        bit po, pe, mo, me;
        clear_hist();
        run_branch(32'h40, 1'b1, po, pe, mo, me);
        n_tests++;
        if (po !== 1'b0 || po !== pe) begin n_fail++; $display("FAIL train_v1: got %b want 0", po); end
        clear_hist();
        run_branch(32'h40, 1'b1, po, pe, mo, me);
        clear_hist();
        n_tests++;
        if (dut.u_pht.cnt_q[16] !== 2'b11) begin n_fail++; $display("FAIL train_ctr: got %b want 11", dut.u_pht.cnt_q[16]); end
        run_branch(32'h40, 1'b0, po, pe, mo, me);
        n_tests++;
        if (po !== 1'b1 || po !== pe) begin n_fail++; $display("FAIL train_v3: got %b want 1", po); end
        clear_hist();
        run_branch(32'h40, 1'b0, po, pe, mo, me);
        clear_hist();
        run_branch(32'h40, 1'b0, po, pe, mo, me);
        n_tests++;
        if (po !== 1'b0 || po !== pe) begin n_fail++; $display("FAIL train_v5: got %b want 0", po); end
        clear_hist();
    endtask

    task automatic test_saturation();
        bit po, pe, mo, me;
        clear_hist();
        for (int i = 0; i < 5; i++) begin
            run_branch(32'h80, 1'b1, po, pe, mo, me);
            clear_hist();
        end
        n_tests++;
        if (dut.u_pht.cnt_q[32] !== 2'b11) begin n_fail++; $display("FAIL sat_hi: got %b want 11", dut.u_pht.cnt_q[32]); end
        run_branch(32'h80, 1'b0, po, pe, mo, me);
        clear_hist();
        n_tests++;
        if (dut.u_pht.cnt_q[32] !== 2'b10) begin n_fail++; $display("FAIL sat_dec: got %b want 10", dut.u_pht.cnt_q[32]); end
        idle_inputs(); pcF = 32'h80; #1;
        n_tests++;
        if (pred_takenF !== 1'b1) begin n_fail++; $display("FAIL sat_pred: got %b want 1", pred_takenF); end
        idle_inputs();
    endtask

    task automatic test_mispredict();
        bit po, pe, mo, me;
        logic [31:0] mc0;
        clear_hist();
        for (int i = 0; i < 4; i++) run_branch(32'h100, 1'b1, po, pe, mo, me);
        n_tests++;
        if (dut.ghr_spec_q !== 8'h0F) begin n_fail++; $display("FAIL mis_setup: ghr %h want 0f", dut.ghr_spec_q); end
        idle_inputs(); pcF = 32'h3C0; #1;
        step();
        pcF = 32'h7C0; branchD = 1; #1;
        step();
        n_tests++;
        if (dut.ghr_spec_q !== 8'h1E) begin n_fail++; $display("FAIL mis_spec: ghr %h want 1e", dut.ghr_spec_q); end
        pcF = '0; branchD = 1; actual_takenE = 1; #1;
        mc0 = mispred_cnt;
        n_tests++;
        if (mispredictE !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", mispredictE); end
        step();
        n_tests++;
        if (dut.ghr_spec_q !== 8'h1F) begin n_fail++; $display("FAIL mis_recover: ghr %h want 1f", dut.ghr_spec_q); end
        n_tests++;
        if (mispred_cnt !== mc0 + 32'd1) begin n_fail++; $display("FAIL mis_cnt: got %0d want %0d", mispred_cnt, mc0 + 1); end
        branchD = 0; actual_takenE = 0; #1;
        step();
        n_tests++;
        if (dut.ghr_spec_q !== 8'(m_ghr) || mispred_cnt !== m_mcnt) begin
            n_fail++; $display("FAIL mis_after: ghr %h mcnt %0d want %h %0d", dut.ghr_spec_q, mispred_cnt, 8'(m_ghr), m_mcnt);
        end
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        logic [31:0] b0;
        logic [7:0]  g0;
        int          k;
        clear_hist();
        b0 = branch_cnt; g0 = dut.ghr_spec_q;
        idle_inputs(); pcF = 32'h240; #1;
        step();
        for (int i = 0; i < 3; i++) begin
            stallD = 1; branchD = 1; #1;
            step();
            n_tests++;
            if (dut.ghr_spec_q !== g0 || branch_cnt !== b0 || mispredictE !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: ghr %h bcnt %0d misE %b want %h %0d 0", i, dut.ghr_spec_q, branch_cnt, mispredictE, g0, b0);
            end
        end
        stallD = 0; branchD = 1; #1;
        step();
        n_tests++;
        if (dut.ghr_spec_q !== 8'(m_ghr)) begin n_fail++; $display("FAIL stall_shift: ghr %h want %h", dut.ghr_spec_q, 8'(m_ghr)); end
        branchD = 0; #1;
        step(); step(); step();
        n_tests++;
        if (branch_cnt !== b0 + 32'd1) begin n_fail++; $display("FAIL stall_bcnt: got %0d want %0d", branch_cnt, b0 + 1); end
        k = 0;
        while (k < 255 && m_pht[k ^ m_ghr] < 2) k++;
        pcF = 32'(k) << 2; #1;
        step();
        n_tests++;
        if (pred_takenD !== 1'b1) begin n_fail++; $display("FAIL flush_pre: predD %b want 1", pred_takenD); end
        stallD = 1; flushD = 1; #1;
        step();
        n_tests++;
        if (pred_takenD !== 1'b0 || dut.fd_q !== '0) begin
            n_fail++; $display("FAIL flush_stall: predD %b fd %h want 0 0", pred_takenD, dut.fd_q);
        end
        idle_inputs(); #1;
        step();
    endtask

    task automatic test_alternating();
        bit po, pe, mo, me;
        logic [31:0] mc16;
        clear_hist();
        mc16 = '0;
        for (int i = 0; i < 40; i++) begin
            run_branch(32'h2C0, (i % 2) == 0, po, pe, mo, me);
            n_tests++;
            if (mo !== me || po !== pe) begin n_fail++; $display("FAIL alt_%0d: pred %b mis %b want %b %b", i, po, mo, pe, me); end
            if (i == 15) mc16 = mispred_cnt;
        end
        n_tests++;
        if (mispred_cnt !== mc16) begin n_fail++; $display("FAIL alt_converge: mcnt %0d want %0d", mispred_cnt, mc16); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pcF           = {$urandom_range(0, 15), 10'h0} | (32'($urandom_range(0, 31)) << 2);
            branchD       = ($urandom_range(0, 99) < 40);
            actual_takenE = ($urandom_range(0, 99) < 60);
            stallD        = ($urandom_range(0, 99) < 15);
            flushD        = ($urandom_range(0, 99) < 8);
            flushE        = ($urandom_range(0, 99) < 8);
            #1;
            n_tests++;
            if (pred_takenF !== m_predF() || pred_takenD !== m_fd_pred[0] || mispredictE !== m_mis()) begin
                n_fail++; $display("FAIL rand_comb%0d: F %b D %b E %b want %b %b %b", i, pred_takenF, pred_takenD, mispredictE, m_predF(), m_fd_pred[0], m_mis());
            end
            step();
            n_tests++;
            if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt || dut.ghr_spec_q !== 8'(m_ghr)) begin
                n_fail++; $display("FAIL rand_state%0d: bcnt %0d mcnt %0d ghr %h want %0d %0d %h", i, branch_cnt, mispred_cnt, dut.ghr_spec_q, m_bcnt, m_mcnt, 8'(m_ghr));
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midrun();
        idle_inputs(); branchD = 1; actual_takenE = 1; #2;
        rst = 1; #1;
        for (int i = 0; i < 3; i++) begin
            pcF = $urandom; #1;
            n_tests++;
            if (pred_takenF !== 1'b0) begin n_fail++; $display("FAIL midrst_predF: got %b want 0", pred_takenF); end
        end
        n_tests++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || dut.ghr_spec_q !== 8'd0 || pred_takenD !== 1'b0 || mispredictE !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: bcnt %0d mcnt %0d ghr %h predD %b misE %b want all 0", branch_cnt, mispred_cnt, dut.ghr_spec_q, pred_takenD, mispredictE);
        end
        step();
        n_tests++;
        if (branch_cnt !== 32'd0 || dut.ghr_spec_q !== 8'd0) begin
            n_fail++; $display("FAIL midrst_edge: bcnt %0d ghr %h want 0 0", branch_cnt, dut.ghr_spec_q);
        end
        rst = 0; idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_training();
        test_saturation();
        test_mispredict();
        test_stall_flush();
        test_alternating();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
